// File: rtl/vend_ctrl.sv
// vend_ctrl -- transaction controller for a two-product coin vending path.
//
// Holds the running credit, sequences each sale (collect coins, select,
// stock/credit check, dispense, return change in 5Rs steps), keeps per-product
// stock, and handles cancel, inactivity refund and restock.
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous active-low reset
//   coin_in       00 none, 01 5Rs, 10 10Rs, 11 15Rs (one coin per cycle)
//   sel_valid     one-cycle product select strobe
//   sel           0 = product A, 1 = product B (qualified by sel_valid)
//   cancel        refund request pulse
//   restock       reload both stock counters to STOCK_INIT
//   dispense_a/b  one-cycle release pulse, high during the VEND cycle
//   change_pulse  each high cycle returns one 5Rs coin
//   coin_reject   previous cycle's coin returned unaccepted
//   sel_err       previous cycle's select refused
//   credit        current credit in Rs
//   stock_a/b     remaining units per product
//   busy          high while in VEND or CHANGE
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no credit, waiting for the first coin
// COLLECT | accumulating credit, waiting for select/cancel/timeout
// VEND    | one-cycle dispense of the chosen product
// CHANGE  | returning remaining credit, one 5Rs coin per cycle

module vend_ctrl #(
    parameter int PRICE_A    = 10,
    parameter int PRICE_B    = 15,
    parameter int CREDIT_MAX = 30,
    parameter int STOCK_INIT = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] coin_in,
    input  logic       sel_valid,
    input  logic       sel,
    input  logic       cancel,
    input  logic       restock,
    output logic       dispense_a,
    output logic       dispense_b,
    output logic       change_pulse,
    output logic       coin_reject,
    output logic       sel_err,
    output logic [5:0] credit,
    output logic [3:0] stock_a,
    output logic [3:0] stock_b,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_t;

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);
    localparam logic [6:0]    PRICE_A7    = 7'(PRICE_A);
    localparam logic [6:0]    PRICE_B7    = 7'(PRICE_B);
    localparam logic [6:0]    CREDIT_MAX7 = 7'(CREDIT_MAX);
    localparam logic [3:0]    STOCK_INIT4 = 4'(STOCK_INIT);

    state_t        state_q, state_d;
    logic [5:0]    credit_q, credit_d;
    logic [3:0]    stock_a_q, stock_a_d;
    logic [3:0]    stock_b_q, stock_b_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          dispense_a_q, dispense_a_d;
    logic          dispense_b_q, dispense_b_d;
    logic          change_pulse_q, change_pulse_d;
    logic          coin_reject_q, coin_reject_d;
    logic          sel_err_q, sel_err_d;
    logic          busy_q, busy_d;

    logic [6:0] coin_val;
    logic       coin_present;
    logic [6:0] credit_ext;
    logic [6:0] credit_sum;
    logic [6:0] sel_price;
    logic [3:0] sel_stock;

    always_comb begin
        case (coin_in)
            2'b01:   coin_val = 7'd5;
            2'b10:   coin_val = 7'd10;
            2'b11:   coin_val = 7'd15;
            default: coin_val = 7'd0;
        endcase
        coin_present = (coin_in != 2'b00);
        // 7-bit so that a full credit plus the largest coin cannot wrap
        credit_ext   = {1'b0, credit_q};
        credit_sum   = credit_ext + coin_val;
        sel_price    = sel ? PRICE_B7 : PRICE_A7;
        sel_stock    = sel ? stock_b_q : stock_a_q;

        state_d       = state_q;
        credit_d      = credit_q;
        stock_a_d     = stock_a_q;
        stock_b_d     = stock_b_q;
        timer_d       = '0;
        dispense_a_d  = 1'b0;
        dispense_b_d  = 1'b0;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                sel_err_d = sel_valid;
                if (coin_present) begin
                    state_d  = S_COLLECT;
                    credit_d = coin_val[5:0];
                end
            end

            S_COLLECT: begin
                if (cancel) begin
                    state_d       = S_CHANGE;
                    coin_reject_d = coin_present;
                end else if (sel_valid) begin
                    coin_reject_d = coin_present;
                    if (sel_stock == 4'd0 || credit_ext < sel_price) begin
                        sel_err_d = 1'b1;
                    end else begin
                        state_d  = S_VEND;
                        credit_d = 6'(credit_ext - sel_price);
                        if (sel) begin
                            stock_b_d    = stock_b_q - 4'd1;
                            dispense_b_d = 1'b1;
                        end else begin
                            stock_a_d    = stock_a_q - 4'd1;
                            dispense_a_d = 1'b1;
                        end
                    end
                end else if (coin_present) begin
                    if (credit_sum <= CREDIT_MAX7) begin
                        credit_d = credit_sum[5:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_CHANGE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_VEND: begin
                coin_reject_d = coin_present;
                sel_err_d     = sel_valid;
                state_d       = (credit_q != 6'd0) ? S_CHANGE : S_IDLE;
            end

            S_CHANGE: begin
                coin_reject_d = coin_present;
                sel_err_d     = sel_valid;
                credit_d      = credit_q - 6'd5;
                if (credit_q == 6'd5) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // restock overrides a decrement in the same cycle
        if (restock) begin
            stock_a_d = STOCK_INIT4;
            stock_b_d = STOCK_INIT4;
        end

        busy_d         = (state_d == S_VEND) || (state_d == S_CHANGE);
        change_pulse_d = (state_d == S_CHANGE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            credit_q       <= 6'd0;
            stock_a_q      <= STOCK_INIT4;
            stock_b_q      <= STOCK_INIT4;
            timer_q        <= '0;
            dispense_a_q   <= 1'b0;
            dispense_b_q   <= 1'b0;
            change_pulse_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            sel_err_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            stock_a_q      <= stock_a_d;
            stock_b_q      <= stock_b_d;
            timer_q        <= timer_d;
            dispense_a_q   <= dispense_a_d;
            dispense_b_q   <= dispense_b_d;
            change_pulse_q <= change_pulse_d;
            coin_reject_q  <= coin_reject_d;
            sel_err_q      <= sel_err_d;
            busy_q         <= busy_d;
        end
    end

    assign dispense_a   = dispense_a_q;
    assign dispense_b   = dispense_b_q;
    assign change_pulse = change_pulse_q;
    assign coin_reject  = coin_reject_q;
    assign sel_err      = sel_err_q;
    assign credit       = credit_q;
    assign stock_a      = stock_a_q;
    assign stock_b      = stock_b_q;
    assign busy         = busy_q;

endmodule
